fme_clip_pipe: RTL and testbench

Parametrised, pipelined round-shift-and-clip stage for the FME interpolation datapath. It converts NCH signed filter sums of IN_WIDTH bits into unsigned DATAWIDTH-bit samples. The shift is selectable per beat: the two-pass (pvso) path or the single-pass path. A valid/ready handshake and per-frame saturation counters replace the fixed 27-lane registered clip cells. It sits between the interpolation filter array and the SAD/Hadamard cost stage.

---
 rtl/fme_clip_pkg.sv | 17 +
 rtl/fme_clip_pipe_if.sv | 26 ++
 rtl/fme_clip_lane.sv | 43 ++++
 rtl/fme_clip_pipe.sv | 101 ++++++++++
 tb/tb_fme_clip_pipe.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fme_clip_pkg.sv
// Shared constants and helpers for the FME round-shift-and-clip stage.
package fme_clip_pkg;

  localparam int unsigned SHIFT_PVSO   = 7;
  localparam int unsigned SHIFT_DIRECT = 1;

  // Shift amount selected by the per-beat mode bit.
  function automatic int unsigned shift_for(input logic pvso);
    return pvso ? SHIFT_PVSO : SHIFT_DIRECT;
  endfunction

  // Round-half-up offset added before an arithmetic right shift by s.
  function automatic int unsigned rnd_offset(input int unsigned s);
    return (s == 0) ? 32'd0 : (32'd1 << (s - 1));
  endfunction

endpackage

// File: rtl/fme_clip_pipe_if.sv
// Input/output stream bundle of the clip stage (valid/ready on both sides).
interface fme_clip_pipe_if #(
  parameter int DATAWIDTH = 8,
  parameter int IN_WIDTH  = 23,
  parameter int NCH       = 27
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_pvso;
  logic [NCH*IN_WIDTH-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [NCH*DATAWIDTH-1:0]  out_data;

  // Environment side: produces input beats, consumes output beats.
  modport master (
    output in_valid, in_pvso, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, in_pvso, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fme_clip_lane.sv
// One lane: combinational round-shift feeding S1, and clip with hi/lo flags
// operating on the S1-registered value feeding S2.
module fme_clip_lane
  import fme_clip_pkg::*;
#(
  parameter  int DATAWIDTH = 8,
  parameter  int IN_WIDTH  = 23,
  localparam int W1        = IN_WIDTH + 1
) (
  input  logic [IN_WIDTH-1:0]  x,
  input  logic                 pvso,
  output logic [W1-1:0]        y,
  input  logic [W1-1:0]        y_reg,
  output logic [DATAWIDTH-1:0] q,
  output logic                 hi,
  output logic                 lo
);

  localparam int unsigned SP = shift_for(1'b1);
  localparam int unsigned SD = shift_for(1'b0);
  localparam logic signed [W1-1:0] OFF_P = W1'(rnd_offset(SP));
  localparam logic signed [W1-1:0] OFF_D = W1'(rnd_offset(SD));

  logic signed [W1-1:0] ext, sum_p, sum_d;

  // Round and shift in one extra bit so the offset add cannot overflow.
  always_comb begin
    ext   = {x[IN_WIDTH-1], x};
    sum_p = ext + OFF_P;
    sum_d = ext + OFF_D;
    y     = pvso ? (sum_p >>> SP) : (sum_d >>> SD);
  end

  // Clip to [0, 2^DATAWIDTH-1]; any set bit above the sample width means overflow.
  always_comb begin
    lo = y_reg[W1-1];
    hi = !y_reg[W1-1] && (|y_reg[W1-2:DATAWIDTH]);
    if (lo)      q = '0;
    else if (hi) q = '1;
    else         q = y_reg[DATAWIDTH-1:0];
  end

endmodule

// File: rtl/fme_clip_pipe.sv
// Two-stage round-shift-and-clip pipeline with valid/ready flow control and
// saturating per-frame clip-event counters.
module fme_clip_pipe
  import fme_clip_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int IN_WIDTH  = 23,
  parameter int NCH       = 27,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  fme_clip_pipe_if.slave       io,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] sat_hi_cnt,
  output logic [CNT_WIDTH-1:0] sat_lo_cnt
);

  localparam int W1  = IN_WIDTH + 1;
  localparam int CW1 = CNT_WIDTH + 1;

  logic                          s1_valid, s2_valid, adv1, adv2, xfer;
  logic [NCH-1:0][IN_WIDTH-1:0]  lane_x;
  logic [NCH-1:0][W1-1:0]        y_nxt, s1_y;
  logic [NCH-1:0][DATAWIDTH-1:0] q_nxt, s2_q;
  logic [NCH-1:0]                hi_nxt, lo_nxt, s2_hi, s2_lo;
  logic [CW1-1:0]                hi_pop, lo_pop, hi_sum, lo_sum;

  assign lane_x       = io.in_data;
  assign adv2         = enable & (~s2_valid | io.out_ready);
  assign adv1         = enable & (~s1_valid | adv2);
  assign io.in_ready  = adv1;
  assign io.out_valid = s2_valid;
  assign io.out_data  = s2_q;
  assign xfer         = enable & s2_valid & io.out_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    fme_clip_lane #(.DATAWIDTH(DATAWIDTH), .IN_WIDTH(IN_WIDTH)) u_lane (
      .x     (lane_x[k]),
      .pvso  (io.in_pvso),
      .y     (y_nxt[k]),
      .y_reg (s1_y[k]),
      .q     (q_nxt[k]),
      .hi    (hi_nxt[k]),
      .lo    (lo_nxt[k])
    );
  end

  // S1: capture rounded lanes; mode is already folded in, so no mode bit travels on.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
    end else if (adv1) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) s1_y <= y_nxt;
    end
  end

  // S2: capture clipped lanes and event flags; held while stalled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
      s2_hi    <= '0;
      s2_lo    <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q  <= q_nxt;
        s2_hi <= hi_nxt;
        s2_lo <= lo_nxt;
      end
    end
  end

  // Popcount of the outgoing beat's flags, added with one headroom bit.
  always_comb begin
    hi_pop = '0;
    lo_pop = '0;
    for (int k = 0; k < NCH; k++) begin
      hi_pop = hi_pop + CW1'(s2_hi[k]);
      lo_pop = lo_pop + CW1'(s2_lo[k]);
    end
    hi_sum = {1'b0, sat_hi_cnt} + hi_pop;
    lo_sum = {1'b0, sat_lo_cnt} + lo_pop;
  end

  // Saturating counters; a clear beats a coincident transfer.
  always_ff @(posedge clock) begin
    if (!reset_n || (enable && cnt_clr)) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (xfer) begin
      sat_hi_cnt <= hi_sum[CNT_WIDTH] ? '1 : hi_sum[CNT_WIDTH-1:0];
      sat_lo_cnt <= lo_sum[CNT_WIDTH] ? '1 : lo_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_fme_clip_pipe.sv
// Bench for fme_clip_pipe: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model of the stage.
module tb_fme_clip_pipe;

  localparam int DW   = 8;
  localparam int IW   = 23;
  localparam int NCH  = 27;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] sat_hi_cnt, sat_lo_cnt;

  fme_clip_pipe_if #(.DATAWIDTH(DW), .IN_WIDTH(IW), .NCH(NCH)) bus ();

  fme_clip_pipe #(.DATAWIDTH(DW), .IN_WIDTH(IW), .NCH(NCH), .CNT_WIDTH(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .io         (bus),
    .cnt_clr    (cnt_clr),
    .sat_hi_cnt (sat_hi_cnt),
    .sat_lo_cnt (sat_lo_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [NCH*DW-1:0] act, input logic [NCH*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [NCH*DW-1:0] q;
    int                hi;
    int                lo;
    int                age;
  } beat_t;

  beat_t mq[$];
  int    m_hi = 0, m_lo = 0;
  bit    armed = 0;

  // Rounded divide by 2^s (floor), then clip to the sample range.
  function automatic void lane_ref(input longint x, input bit pvso,
                                   output int q, output bit hi, output bit lo);
    longint s, num, den, y;
    s   = pvso ? 7 : 1;
    den = longint'(1) << s;
    num = x + den / 2;
    y   = num / den;
    if ((num % den != 0) && (num < 0)) y = y - 1;
    hi  = (y > 255);
    lo  = (y < 0);
    q   = lo ? 0 : (hi ? 255 : int'(y));
  endfunction

  function automatic beat_t make_beat(input logic [NCH*IW-1:0] d, input bit pvso);
    beat_t            b;
    logic signed [IW-1:0] xs;
    int               q;
    bit               h, l;
    b.q = '0; b.hi = 0; b.lo = 0; b.age = 1;
    for (int k = 0; k < NCH; k++) begin
      xs = d[k*IW +: IW];
      lane_ref(longint'(xs), pvso, q, h, l);
      b.q[k*DW +: DW] = q[DW-1:0];
      b.hi += int'(h);
      b.lo += int'(l);
    end
    return b;
  endfunction

  // Per-cycle compare, then advance the model by what the coming edge does.
  always @(negedge clock) begin
    bit    ev, er;
    beat_t head;
    ev = (mq.size() > 0) && (mq[0].age >= 2);
    er = enable && ((mq.size() < 2) || bus.out_ready);
    if (armed) begin
      chk("out_valid", bus.out_valid, ev);
      if (ev) chkv("out_data", bus.out_data, mq[0].q);
      chk("in_ready", bus.in_ready, er);
      chk("sat_hi_cnt", sat_hi_cnt, m_hi);
      chk("sat_lo_cnt", sat_lo_cnt, m_lo);
    end
    if (!reset_n) begin
      mq.delete();
      m_hi = 0; m_lo = 0;
      armed = 1;
    end else if (armed && enable) begin
      if (ev && bus.out_ready) begin
        head = mq.pop_front();
        m_hi = (m_hi + head.hi > CMAX) ? CMAX : m_hi + head.hi;
        m_lo = (m_lo + head.lo > CMAX) ? CMAX : m_lo + head.lo;
      end
      if (cnt_clr) begin m_hi = 0; m_lo = 0; end
      foreach (mq[i]) mq[i].age++;
      if (bus.in_valid && er) mq.push_back(make_beat(bus.in_data, bus.in_pvso));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic [NCH*IW-1:0] lanes5(input int a, input int b, input int c,
                                              input int d, input int e);
    logic [NCH*IW-1:0] r;
    int v[5];
    r = '0;
    v = '{a, b, c, d, e};
    for (int k = 0; k < 5; k++) r[k*IW +: IW] = v[k][IW-1:0];
    return r;
  endfunction

  function automatic logic [NCH*IW-1:0] all_lanes(input int v);
    logic [NCH*IW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*IW +: IW] = v[IW-1:0];
    return r;
  endfunction

  task automatic send(input logic [NCH*IW-1:0] d, input bit pvso);
    int n;
    bit acc;
    n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_pvso = pvso;
    do begin
      @(negedge clock);
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    chk("send_accept", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain", mq.size(), 0);
  endtask

  int exp_p[5] = '{255, 255, 255, 0, 0};
  int exp_d[4] = '{150, 255, 255, 0};

  initial begin
    int q; bit h, l;
    bus.in_valid = 1'b0; bus.in_pvso = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

    // Pin the model with hand-computed lane results.
    lane_ref(32640, 1, q, h, l); chk("ref_p32640", {q, h, l}, {32'd255, 2'b00});
    lane_ref(32703, 1, q, h, l); chk("ref_p32703", {q, h, l}, {32'd255, 2'b00});
    lane_ref(32704, 1, q, h, l); chk("ref_p32704", {q, h, l}, {32'd255, 2'b10});
    lane_ref(-64,   1, q, h, l); chk("ref_p-64",   {q, h, l}, {32'd0,   2'b00});
    lane_ref(-65,   1, q, h, l); chk("ref_p-65",   {q, h, l}, {32'd0,   2'b01});
    lane_ref(300,   0, q, h, l); chk("ref_d300",   {q, h, l}, {32'd150, 2'b00});
    lane_ref(511,   0, q, h, l); chk("ref_d511",   {q, h, l}, {32'd255, 2'b10});
    lane_ref(-3,    0, q, h, l); chk("ref_d-3",    {q, h, l}, {32'd0,   2'b01});
    lane_ref(128,   1, q, h, l); chk("ref_p128",   q, 1);
    lane_ref(128,   0, q, h, l); chk("ref_d128",   q, 64);

    // Reset state.
    enable = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_out_valid", bus.out_valid, 0);
    chkv("rst_out_data", bus.out_data, '0);
    chk("rst_hi", sat_hi_cnt, 0);
    chk("rst_lo", sat_lo_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // pvso clip cases and latency.
    send(lanes5(32640, 32703, 32704, -64, -65), 1'b1);
    chk("lat_pvso_early", bus.out_valid, 0);
    tick();
    chk("lat_pvso", bus.out_valid, 1);
    for (int k = 0; k < 5; k++) chk("pvso_lane", bus.out_data[k*DW +: DW], exp_p[k]);
    tick();
    chk("pvso_hi_cnt", sat_hi_cnt, 1);
    chk("pvso_lo_cnt", sat_lo_cnt, 1);

    // Direct mode clip cases.
    send(lanes5(300, 509, 511, -3, 0), 1'b0);
    tick();
    for (int k = 0; k < 4; k++) chk("direct_lane", bus.out_data[k*DW +: DW], exp_d[k]);
    tick();
    chk("direct_hi_cnt", sat_hi_cnt, 2);
    chk("direct_lo_cnt", sat_lo_cnt, 2);

    // Alternating mode, back to back.
    for (int i = 0; i < 8; i++) send(all_lanes(128), i[0]);
    drain();

    // Backpressure mid-stream.
    fork
      for (int i = 0; i < 6; i++) send(all_lanes(1000 + 256 * i), 1'b1);
      begin
        tick(); tick(); tick();
        bus.out_ready = 1'b0;
        tick(); tick();
        @(negedge clock);
        chk("bp_in_ready", bus.in_ready, 0);
        tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Enable low with a full pipeline.
    bus.out_ready = 1'b0;
    send(all_lanes(5000), 1'b1);
    send(all_lanes(-5000), 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("en_in_ready", bus.in_ready, 0);
    chk("en_out_valid", bus.out_valid, 1);
    enable = 1'b1;
    bus.out_ready = 1'b1;
    drain();

    // Counter saturation.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_hi", sat_hi_cnt, 0);
    for (int i = 0; i < 2428; i++) send(all_lanes(32704), 1'b1);
    drain();
    tick();
    chk("sat_hi_max", sat_hi_cnt, CMAX);
    chk("sat_lo_zero", sat_lo_cnt, 0);

    // Clear coincident with a transfer carrying hi events.
    bus.out_ready = 1'b0;
    send(all_lanes(32704), 1'b1);
    tick();
    cnt_clr = 1'b1; bus.out_ready = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_xfer_hi", sat_hi_cnt, 0);
    chk("clr_xfer_valid", bus.out_valid, 0);

    // Reset with two beats in flight.
    send(all_lanes(40000), 1'b1);
    drain();
    tick();
    chk("pre_rst_hi", sat_hi_cnt, 27);
    bus.out_ready = 1'b0;
    send(all_lanes(-9000), 1'b1);
    send(all_lanes(9000), 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_hi", sat_hi_cnt, 0);
    chk("mrst_lo", sat_lo_cnt, 0);
    bus.out_ready = 1'b1;
    send(all_lanes(700), 1'b0);
    chk("mrst_lat_early", bus.out_valid, 0);
    tick();
    chk("mrst_lat", bus.out_valid, 1);
    drain();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [NCH*IW-1:0] d;
      bit                pv;
      int                v;
      pv = $urandom_range(1);
      for (int k = 0; k < NCH; k++) begin
        case ($urandom_range(15))
          0:       v = -(1 << (IW - 1));
          1:       v = (1 << (IW - 1)) - 1;
          default: v = pv ? int'($urandom_range(70000)) - 35000 : int'($urandom_range(1400)) - 700;
        endcase
        d[k*IW +: IW] = v[IW-1:0];
      end
      bus.in_data   = d;
      bus.in_pvso   = pv;
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      enable        = ($urandom_range(9) != 0);
      cnt_clr       = ($urandom_range(63) == 0);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; enable = 1'b1; cnt_clr = 1'b0;
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
